// File: rtl/instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// instr_fetch_decode
//
// Control stage that sits directly after the 3-bit program counter. It keeps
// an 8 x 8-bit instruction store that is written over a program port. It
// fetches the instruction at pc and decodes it into execute-stage controls.
// Each instruction is issued over a valid/ready handshake. The stage then
// pulses pc_inc, or pc_load with a jump target.
//
// Instruction format: opcode = instr[7:5], operand = instr[4:2],
// reg_sel = instr[1:0].
// Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 LD, 101 ST, 110 JMP, 111 HLT.
//
// Ports:
//   clk, rst          system clock (rising edge); synchronous active-high reset
//   start             leave IDLE and begin fetching
//   pc                current program counter value
//   prog_we/addr/data instruction-store write port (accepted in any state)
//   pc_inc, pc_load   one-cycle PC update pulses; pc_target valid with pc_load
//   out_valid/ready   issue handshake to the execute stage
//   alu_op, reg_sel,
//   operand, mem_rd,
//   mem_wr            decoded controls, non-zero only while issuing
//   halted            HLT has executed; held until rst
//   retire_cnt        only with RETIRE_CNT_EN defined: saturating count of
//                     transfers (out_valid && out_ready)
//
// Optional build macro: RETIRE_CNT_EN
// -----------------------------------------------------------------------------
module instr_fetch_decode #(
  parameter int ADDR_W  = 3,
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         alu_op,
  output logic [1:0]         reg_sel,
  output logic [2:0]         operand,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               halted
`ifdef RETIRE_CNT_EN
  ,
  output logic [7:0]         retire_cnt
`endif
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_ISSUE   = 3'd3,
    S_ADVANCE = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t state_reg, state_next;

  logic [INSTR_W-1:0] mem_reg [DEPTH];
  logic [INSTR_W-1:0] instr_reg;
  logic [DEPTH-1:0]   wr_hit;

  logic [1:0] alu_op_reg, alu_op_next;
  logic [1:0] reg_sel_reg;
  logic [2:0] operand_reg;
  logic       mem_rd_reg, mem_rd_next;
  logic       mem_wr_reg, mem_wr_next;

  logic [2:0] opcode;
  assign opcode = instr_reg[INSTR_W-1 -: 3];

  // One write-enable per store entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_hit
      assign wr_hit[gi] = prog_we && (prog_addr == ADDR_W'(gi));
    end
  endgenerate

  // Instruction store. Reset clears every entry to NOP and wins over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          mem_reg[i] <= prog_data;
        end
      end
    end
  end

  // Registered fetch. The read samples the pre-edge contents, so a same-cycle
  // write to the fetched address is seen only on the next visit.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg <= '0;
    end else if (state_reg == S_FETCH) begin
      instr_reg <= mem_reg[pc];
    end
  end

  // Opcode to control mapping. This is only captured during DECODE.
  always_comb begin
    alu_op_next = 2'b00;
    mem_rd_next = 1'b0;
    mem_wr_next = 1'b0;
    case (opcode)
      OP_ADD: alu_op_next = 2'b00;
      OP_SUB: alu_op_next = 2'b01;
      OP_AND: alu_op_next = 2'b10;
      OP_LD: begin
        alu_op_next = 2'b11;
        mem_rd_next = 1'b1;
      end
      OP_ST: begin
        alu_op_next = 2'b11;
        mem_wr_next = 1'b1;
      end
      default: alu_op_next = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_reg  <= '0;
      reg_sel_reg <= '0;
      operand_reg <= '0;
      mem_rd_reg  <= 1'b0;
      mem_wr_reg  <= 1'b0;
    end else if (state_reg == S_DECODE) begin
      alu_op_reg  <= alu_op_next;
      reg_sel_reg <= instr_reg[1:0];
      operand_reg <= instr_reg[4:2];
      mem_rd_reg  <= mem_rd_next;
      mem_wr_reg  <= mem_wr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and outputs. Decoded fields are driven only in ISSUE. They
  // come from registers that do not change there, so they stay stable under
  // backpressure.
  always_comb begin
    state_next = state_reg;
    out_valid  = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_target  = '0;
    halted     = 1'b0;
    alu_op     = '0;
    reg_sel    = '0;
    operand    = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP, OP_JMP: state_next = S_ADVANCE;
          OP_HLT:         state_next = S_HALT;
          default:        state_next = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        out_valid = 1'b1;
        alu_op    = alu_op_reg;
        reg_sel   = reg_sel_reg;
        operand   = operand_reg;
        mem_rd    = mem_rd_reg;
        mem_wr    = mem_wr_reg;
        if (out_ready) begin
          state_next = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        // instr_reg still holds the instruction that just finished.
        if (opcode == OP_JMP) begin
          pc_load   = 1'b1;
          pc_target = instr_reg[4:2];
        end else begin
          pc_inc = 1'b1;
        end
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

`ifdef RETIRE_CNT_EN
  logic [7:0] retire_cnt_reg;

  // Only ALU, LD and ST reach ISSUE, so NOP, JMP and HLT never count.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_reg <= '0;
    end else if ((state_reg == S_ISSUE) && out_ready && (retire_cnt_reg != 8'hFF)) begin
      retire_cnt_reg <= retire_cnt_reg + 8'd1;
    end
  end

  assign retire_cnt = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] pc;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [7:0] prog_data;
  logic       pc_inc;
  logic       pc_load;
  logic [2:0] pc_target;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] alu_op;
  logic [1:0] reg_sel;
  logic [2:0] operand;
  logic       mem_rd;
  logic       mem_wr;
  logic       halted;
`ifdef RETIRE_CNT_EN
  logic [7:0] retire_cnt;
`endif

  instr_fetch_decode dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc        (pc),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .reg_sel   (reg_sel),
    .operand   (operand),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .halted    (halted)
`ifdef RETIRE_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model driven by the stage's pulses. It wraps at 3 bits.
  always @(posedge clk) begin
    if (rst) pc <= 3'd0;
    else if (pc_load) pc <= pc_target;
    else if (pc_inc) pc <= pc + 3'd1;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xfer_total = 0;
  int xfer_times[$];
  bit mon_en = 1'b1;
  bit valid_seen = 1'b0;

  // Expected transfers: {alu_op, reg_sel, operand, mem_rd, mem_wr}.
  logic [8:0] exp_q[$];
  // Expected PC events: {pc_inc, pc_load, pc_target}.
  logic [4:0] pc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_t(input logic [1:0] a, input logic [1:0] r,
                                 input logic [2:0] o, input logic rd, input logic w);
    exp_q.push_back({a, r, o, rd, w});
  endfunction

  function automatic void push_p(input logic inc, input logic ld, input logic [2:0] t);
    pc_q.push_back({inc, ld, t});
  endfunction

  // Transfer monitor and scoreboard.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) valid_seen = 1'b1;
      if (!rst && out_valid && out_ready) begin
        xfer_total++;
        xfer_times.push_back(cyc);
        if (mon_en) begin
          $display("xfer alu_op=%0d reg_sel=%0d operand=%0d mem_rd=%0d mem_wr=%0d",
                   alu_op, reg_sel, operand, mem_rd, mem_wr);
          if (exp_q.size() == 0) begin
            chk("unexpected_xfer", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("xfer", {alu_op, reg_sel, operand, mem_rd, mem_wr}, e);
          end
        end
      end
    end
  end

  // PC event monitor.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && (pc_inc || pc_load)) begin
        $display("pc_event inc=%0d load=%0d target=%0d", pc_inc, pc_load, pc_target);
        if (pc_q.size() == 0) begin
          chk("unexpected_pc_event", 32'd1, 32'd0);
        end else begin
          e = pc_q.pop_front();
          chk("pc_event", {pc_inc, pc_load, pc_target}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    pc_q.delete();
    xfer_times.delete();
    valid_seen = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    chk("wait_valid", out_valid, 1'b1);
  endtask

  task automatic wait_halted();
    int n = 0;
    while (!halted && n < 80) begin
      tick();
      n++;
    end
    chk("wait_halted", halted, 1'b1);
  endtask

  task automatic chk_drained(input string name);
    chk({name, "_txn_left"}, exp_q.size(), 0);
    chk({name, "_pc_left"}, pc_q.size(), 0);
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1;
    start = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    out_ready = 1'b0;

    // Reset and idle.
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("idle_outs", {pc_inc, pc_load, pc_target, out_valid, alu_op, reg_sel,
                        operand, mem_rd, mem_wr, halted}, 32'd0);
      tick();
    end

    // Straight-line issue: ADD, SUB, then HLT.
    do_reset();
    out_ready = 1'b1;
    wr(3'd0, 8'h21);
    wr(3'd1, 8'h4A);
    wr(3'd2, 8'hE0);
    push_t(2'b00, 2'b01, 3'b000, 1'b0, 1'b0);
    push_t(2'b01, 2'b10, 3'b010, 1'b0, 1'b0);
    push_p(1'b1, 1'b0, 3'd0);
    push_p(1'b1, 1'b0, 3'd0);
    pulse_start();
    wait_valid(n);
    chk("issue_latency", n, 2);
    wait_halted();
    chk("issue_interval", (xfer_times.size() == 2) ? (xfer_times[1] - xfer_times[0]) : -1, 4);
    chk_drained("straight");
    pulse_start();
    repeat (4) tick();
    chk("halt_ignores_start", {halted, out_valid, pc_inc, pc_load}, 4'b1000);

    // Backpressure on LD.
    do_reset();
    out_ready = 1'b0;
    wr(3'd0, 8'h88);
    wr(3'd1, 8'hE0);
    push_t(2'b11, 2'b00, 3'b010, 1'b1, 1'b0);
    push_p(1'b1, 1'b0, 3'd0);
    pulse_start();
    wait_valid(n);
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold", {out_valid, alu_op, reg_sel, operand, mem_rd, mem_wr, pc_inc},
          {1'b1, 2'b11, 2'b00, 3'b010, 1'b1, 1'b0, 1'b0});
      tick();
    end
    out_ready = 1'b1;
    wait_halted();
    chk("bp_one_xfer", xfer_times.size(), 1);
    chk_drained("bp");

    // NOP, JMP 5, HLT at 5.
    do_reset();
    out_ready = 1'b1;
    wr(3'd0, 8'h00);
    wr(3'd1, 8'hD4);
    wr(3'd5, 8'hE0);
    push_p(1'b1, 1'b0, 3'd0);
    push_p(1'b0, 1'b1, 3'd5);
    pulse_start();
    wait_halted();
    chk("jmp_pc", pc, 3'd5);
    chk("jmp_no_valid", valid_seen, 1'b0);
    chk_drained("jmp");
    pulse_start();
    repeat (4) tick();
    chk("jmp_halt_hold", {halted, out_valid}, 2'b10);

    // Reset while issuing: out_valid drops and the store is cleared.
    do_reset();
    out_ready = 1'b0;
    wr(3'd0, 8'h21);
    pulse_start();
    wait_valid(n);
    rst = 1'b1;
    tick();
    chk("rst_drop_valid", out_valid, 1'b0);
    rst = 1'b0;
    wr(3'd2, 8'hE0);
    push_p(1'b1, 1'b0, 3'd0);
    push_p(1'b1, 1'b0, 3'd0);
    out_ready = 1'b1;
    pulse_start();
    wait_halted();
    chk_drained("rst_clear");

    // Write collides with FETCH of the same address.
    do_reset();
    out_ready = 1'b1;
    wr(3'd0, 8'h21);
    wr(3'd1, 8'hC0);
    push_t(2'b00, 2'b01, 3'b000, 1'b0, 1'b0);
    push_p(1'b1, 1'b0, 3'd0);
    push_p(1'b0, 1'b1, 3'd0);
    push_t(2'b01, 2'b10, 3'b010, 1'b0, 1'b0);
    push_p(1'b1, 1'b0, 3'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    prog_we = 1'b1;
    prog_addr = 3'd0;
    prog_data = 8'h4A;
    tick();
    prog_we = 1'b0;
    wait_valid(n);
    tick();
    wait_valid(n);
    wr(3'd1, 8'hE0);
    wait_halted();
    chk_drained("collision");

`ifdef RETIRE_CNT_EN
    // Three ALU ops, a NOP and a JMP: only the ALU ops retire.
    do_reset();
    chk("retire_reset", retire_cnt, 8'd0);
    out_ready = 1'b1;
    wr(3'd0, 8'h21);
    wr(3'd1, 8'h4A);
    wr(3'd2, 8'h6B);
    wr(3'd3, 8'h00);
    wr(3'd4, 8'hD8);
    wr(3'd6, 8'hE0);
    push_t(2'b00, 2'b01, 3'b000, 1'b0, 1'b0);
    push_t(2'b01, 2'b10, 3'b010, 1'b0, 1'b0);
    push_t(2'b10, 2'b11, 3'b010, 1'b0, 1'b0);
    repeat (4) push_p(1'b1, 1'b0, 3'd0);
    push_p(1'b0, 1'b1, 3'd6);
    pulse_start();
    wait_halted();
    chk("retire_three", retire_cnt, 8'd3);
    chk_drained("retire");

    // Saturation after 300 transfers.
    do_reset();
    mon_en = 1'b0;
    out_ready = 1'b1;
    wr(3'd0, 8'h21);
    wr(3'd1, 8'hC0);
    base = xfer_total;
    pulse_start();
    n = 0;
    while ((xfer_total - base) < 300 && n < 4000) begin
      tick();
      n++;
    end
    chk("retire_300_reached", (xfer_total - base) >= 300, 1'b1);
    chk("retire_saturate", retire_cnt, 8'd255);
    do_reset();
    mon_en = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Control stage directly downstream of the 3-bit program counter.
- Holds an 8-entry, 8-bit instruction store that is loaded over a program port.
- Fetches the instruction at the current PC and decodes it into execute-stage controls.
- Issues each instruction to the execute stage over a valid/ready handshake, then tells the PC to increment or load a jump target.

Parameters:
- ADDR_W, 3, PC/instruction-store address width.
- DEPTH, 8, instruction-store entries; equals 2**ADDR_W.
- INSTR_W, 8, instruction width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching.
- pc  input  ADDR_W  current program counter value.
- prog_we  input  1  instruction-store write enable.
- prog_addr  input  ADDR_W  instruction-store write address.
- prog_data  input  INSTR_W  instruction-store write data.
- pc_inc  output  1  one-cycle pulse: PC += 1.
- pc_load  output  1  one-cycle pulse: PC <= pc_target.
- pc_target  output  ADDR_W  jump target.
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  execute stage accepts the instruction.
- alu_op  output  2  00 ADD, 01 SUB, 10 AND, 11 pass-through.
- reg_sel  output  2  register field, instr[1:0].
- operand  output  3  immediate/address field, instr[4:2].
- mem_rd  output  1  load.
- mem_wr  output  1  store.
- halted  output  1  HLT executed.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst) and overrides everything, including prog_we.
- Reset values:
  - state = IDLE; instruction store all 0x00 (NOP).
  - All outputs 0.
- Encoding: opcode = instr[7:5]:
  - 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 LD, 101 ST, 110 JMP, 111 HLT.
- States:
  - IDLE: wait for start=1, then go to FETCH.
  - FETCH: instr_reg <= mem[pc]. Next state DECODE.
  - DECODE: register alu_op, reg_sel, operand, mem_rd, mem_wr from instr_reg. Next state by opcode:
    - ADD/SUB/AND/LD/ST go to ISSUE.
    - NOP and JMP go to ADVANCE.
    - HLT goes to HALT.
  - ISSUE: out_valid=1. All decoded outputs stay stable while out_valid && !out_ready. Transfer occurs on a cycle with out_valid && out_ready, then go to ADVANCE. out_valid never drops without a transfer.
  - ADVANCE: one cycle.
    - JMP: pc_load=1, pc_target=instr[4:2].
    - All others: pc_inc=1.
    - Next state FETCH.
  - HALT: halted=1; all other outputs 0. Stays in HALT until rst; start is ignored.
- Per-opcode controls:
  - LD: mem_rd=1, alu_op=11.
  - ST: mem_wr=1, alu_op=11.
  - ADD/SUB/AND: alu_op = 00/01/10; mem_rd=mem_wr=0.
- Latency:
  - start high at edge n puts FETCH in cycle n+1.
  - out_valid is first high in cycle n+3.
  - With out_ready held at 1, one instruction issues every 4 cycles.
- PC interaction: the PC updates at the end of the ADVANCE cycle, so the following FETCH sees the new pc. PC wrap 7 to 0 is the counter's job; the fetch simply uses pc.
- Program port:
  - Writes are accepted in any state.
  - If a FETCH and a write hit the same address in the same cycle, FETCH reads the old contents (read-before-write).
- Decoded outputs are zero outside ISSUE, except pc_target, which is valid only while pc_load=1.
- rst asserted mid-handshake: out_valid drops on the next edge with no transfer, and the store is cleared.

Optional Feature:
- RETIRE_CNT_EN defined:
  - Adds output retire_cnt [7:0], reset 0.
  - Increments once per transfer (out_valid && out_ready) and saturates at 255.
  - NOP, JMP and HLT do not count.
- RETIRE_CNT_EN undefined: the port and its counter are absent.

Test Plan:
- Reset and idle: hold rst=1 for 2 cycles, then rst=0 with start=0 for 5 cycles -> all outputs 0, no pc_inc/pc_load.
- Straight-line issue: program mem[0]=0x21 (ADD, reg_sel 01), mem[1]=0x4A (SUB, operand 010, reg 10), pulse start, tie out_ready=1 -> out_valid at cycle 3 with alu_op=00, reg_sel=01. pc_inc on the next cycle. Second issue alu_op=01, operand=2, reg_sel=2.
- Backpressure: mem[0]=0x88 (LD, operand 010), out_ready=0 for 6 cycles then 1 -> out_valid, mem_rd=1, operand=2 held stable for all 6 cycles. Exactly one transfer, then one pc_inc pulse.
- Jump and NOP: mem[0]=0x00, mem[1]=0xD4 (JMP 5), mem[5]=0xE0 (HLT) -> pc_inc at PC 0, pc_load with pc_target=5 at PC 1. halted=1 after decoding mem[5]; out_valid never asserted; start ignored afterwards.
- Mid-operation reset and write collision:
  - Assert rst during ISSUE -> out_valid=0 next cycle, store reads 0x00.
  - prog_we to the address being fetched in a FETCH cycle -> old value decoded; new value decoded on the next visit.
- RETIRE_CNT_EN: issue 3 ALU instructions, 1 NOP and 1 JMP -> retire_cnt=3. Force 300 transfers -> retire_cnt=255.
